mem_port_arbiter: RTL and testbench

- Shares the single-ported 1 MiB unified memory between the instruction-fetch requester (I) and the load/store requester (D).
- Uses valid/ready request and response handshakes, with one transaction in flight at a time.
- D has priority, with a starvation guard for I.
- Sits between the core's fetch/LSU stages and the memory model. Drives the memory's address, data, write-enable and byte-mask inputs, and samples its read-data and out-of-range exception outputs.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port (I) and the load/store port (D). One transaction is in flight at a
// time: IDLE (arbitrate) -> ACCESS (one memory cycle) -> RESP (hold response).
// D has priority; after STARVE_MAX consecutive D grants with I waiting, I wins.
// Optional build macro MEM_ARB_MISALIGN_CHECK_EN turns misaligned requests
// into faulting, side-effect-free accesses.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_exc,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic [63:0] d_req_data,
  input  logic        d_req_wren,
  input  logic [7:0]  d_req_mask,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [63:0] d_rsp_data,
  output logic        d_rsp_exc,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        mem_wren,
  output logic [7:0]  mem_mask,
  input  logic [63:0] mem_resp,
  input  logic        mem_exc
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        own_d;
  logic [3:0]  starve_cnt;

  logic [63:0] req_addr_p1;
  logic [63:0] req_data_p1;
  logic        req_wren_p1;
  logic [7:0]  req_mask_p1;
  logic        req_mis_p1;

  logic [63:0] rsp_data_p2;
  logic        rsp_exc_p2;

  logic        grant_i;
  logic        grant_d;
  logic        mis_now;
  logic        in_access;
  logic        rsp_take;

  // Winner selection: D by default, I when alone or when I has waited too long
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (d_req_valid && (!i_req_valid || starve_cnt != SMAX)) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign mis_now = grant_d ? (d_req_addr[2:0] != 3'd0) : (i_req_addr[1:0] != 2'd0);
`else
  assign mis_now = 1'b0;
`endif

  // Stage p0 -> p1: request accepted in IDLE, latched for the ACCESS cycle
  assign in_access = (state == ACCESS);
  assign mem_addr  = in_access ? req_addr_p1 : 64'd0;
  assign mem_data  = in_access ? req_data_p1 : 64'd0;
  assign mem_mask  = (in_access && !req_mis_p1) ? req_mask_p1 : 8'd0;
  // A write is suppressed when the address faults, is misaligned, or reset hits
  assign mem_wren  = in_access & req_wren_p1 & ~mem_exc & ~req_mis_p1 & ~rst;

  // Stage p1 -> p2: memory result captured into the response registers
  assign i_rsp_valid = (state == RESP) && !own_d;
  assign d_rsp_valid = (state == RESP) && own_d;
  assign i_rsp_data  = i_rsp_valid ? rsp_data_p2[31:0] : 32'd0;
  assign i_rsp_exc   = i_rsp_valid & rsp_exc_p2;
  assign d_rsp_data  = d_rsp_valid ? rsp_data_p2 : 64'd0;
  assign d_rsp_exc   = d_rsp_valid & rsp_exc_p2;

  assign rsp_take = own_d ? d_rsp_ready : i_rsp_ready;

  // Control FSM: state, owning port and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            own_d <= grant_d;
            state <= ACCESS;
            if (grant_i || !i_req_valid) begin
              starve_cnt <= 4'd0;
            end else if (starve_cnt != SMAX) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ACCESS: state <= RESP;
        RESP: begin
          if (rsp_take) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers: request latch on grant, response capture after ACCESS
  always_ff @(posedge clk) begin
    if (grant_d || grant_i) begin
      req_addr_p1 <= grant_d ? d_req_addr : i_req_addr;
      req_data_p1 <= grant_d ? d_req_data : 64'd0;
      req_wren_p1 <= grant_d & d_req_wren;
      req_mask_p1 <= grant_d ? d_req_mask : 8'd0;
      req_mis_p1  <= mis_now;
    end
    if (in_access) begin
      rsp_exc_p2 <= req_mis_p1 | mem_exc;
      if (req_mis_p1 || (own_d && req_wren_p1)) begin
        rsp_data_p2 <= 64'd0;
      end else if (!own_d) begin
        rsp_data_p2 <= {32'd0, mem_resp[31:0]};
      end else begin
        rsp_data_p2 <= mem_resp;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed 1 MiB memory model.
// Build with MEM_ARB_MISALIGN_CHECK_EN defined to cover the alignment check.
module tb_mem_port_arbiter;

  localparam int MEM_BYTES = 1048576;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_exc;
  logic [63:0] i_req_addr;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_wren, d_rsp_valid, d_rsp_ready, d_rsp_exc;
  logic [63:0] d_req_addr, d_req_data, d_rsp_data;
  logic [7:0]  d_req_mask;
  logic [63:0] mem_addr, mem_data, mem_resp;
  logic        mem_wren, mem_exc;
  logic [7:0]  mem_mask;

  logic [7:0]  mem [0:MEM_BYTES-1] = '{default: 8'h00};

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data),
    .i_rsp_exc(i_rsp_exc),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_data(d_req_data), .d_req_wren(d_req_wren), .d_req_mask(d_req_mask),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .d_rsp_exc(d_rsp_exc),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_mask(mem_mask),
    .mem_resp(mem_resp), .mem_exc(mem_exc)
  );

  always #5 clk = ~clk;

  // Combinational little-endian read; faults when the 8-byte window leaves the array
  always_comb begin
    mem_exc  = (mem_addr > 64'(MEM_BYTES - 8));
    mem_resp = 64'd0;
    if (!mem_exc) begin
      for (int b = 0; b < 8; b++) begin
        mem_resp[8*b +: 8] = mem[mem_addr[19:0] + 20'(b)];
      end
    end
  end

  // Byte-masked write, performed whenever the arbiter asserts mem_wren
  always @(posedge clk) begin
    if (mem_wren) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_mask[b]) mem[mem_addr[19:0] + 20'(b)] <= mem_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Full D transaction with rsp_ready high; starts and ends 1 time unit after a posedge in IDLE
  task automatic d_txn(input logic [63:0] a, input logic [63:0] d, input logic w,
                       input logic [7:0] m, input logic [63:0] exp_data, input logic exp_exc,
                       input logic exp_wren, input logic [7:0] exp_mask);
    d_req_valid = 1'b1; d_req_addr = a; d_req_data = d; d_req_wren = w; d_req_mask = m;
    d_rsp_ready = 1'b1;
    #1;
    chk("d_req_ready_idle", d_req_ready, 1);
    chk("i_req_ready_idle", i_req_ready, 0);
    cyc;
    d_req_valid = 1'b0;
    #1;
    chk("d_access_addr", mem_addr, a);
    chk("d_access_data", mem_data, d);
    chk("d_access_wren", mem_wren, exp_wren);
    chk("d_access_mask", mem_mask, exp_mask);
    chk("d_access_rsp_valid", d_rsp_valid, 0);
    cyc;
    chk("d_rsp_valid", d_rsp_valid, 1);
    chk("d_rsp_data", d_rsp_data, exp_data);
    chk("d_rsp_exc", d_rsp_exc, exp_exc);
    chk("d_rsp_i_valid", i_rsp_valid, 0);
    chk("d_rsp_mem_wren", mem_wren, 0);
    cyc;
    chk("d_back_idle", d_rsp_valid, 0);
  endtask

  task automatic i_txn(input logic [63:0] a, input logic [31:0] exp_data, input logic exp_exc);
    i_req_valid = 1'b1; i_req_addr = a; i_rsp_ready = 1'b1;
    #1;
    chk("i_req_ready_idle", i_req_ready, 1);
    chk("d_req_ready_idle", d_req_ready, 0);
    cyc;
    i_req_valid = 1'b0;
    #1;
    chk("i_access_addr", mem_addr, a);
    chk("i_access_wren", mem_wren, 0);
    chk("i_access_mask", mem_mask, 0);
    cyc;
    chk("i_rsp_valid", i_rsp_valid, 1);
    chk("i_rsp_data", i_rsp_data, exp_data);
    chk("i_rsp_exc", i_rsp_exc, exp_exc);
    chk("i_rsp_d_valid", d_rsp_valid, 0);
    cyc;
    chk("i_back_idle", i_rsp_valid, 0);
  endtask

  initial begin
    logic exp_i;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = 64'd0; i_rsp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_addr = 64'd0; d_req_data = 64'd0;
    d_req_wren = 1'b0; d_req_mask = 8'd0; d_rsp_ready = 1'b0;
    cyc;
    cyc;
    #1;
    chk("rst_i_rsp_valid", i_rsp_valid, 0);
    chk("rst_d_rsp_valid", d_rsp_valid, 0);
    chk("rst_d_rsp_data", d_rsp_data, 0);
    chk("rst_d_rsp_exc", d_rsp_exc, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_mask", mem_mask, 0);
    rst = 1'b0;
    cyc;

    // Preload the fetch area: bytes 0x100.. = 13 00 00 00 DD CC BB AA
    d_txn(64'h100, 64'hAABBCCDD_00000013, 1'b1, 8'hFF, 64'd0, 1'b0, 1'b1, 8'hFF);
    chk("preload_byte_104", {56'd0, mem[20'h104]}, 64'hDD);

    i_txn(64'h100, 32'h00000013, 1'b0);

    // Partial store then load back
    d_txn(64'h200, 64'h11223344_55667788, 1'b1, 8'h0F, 64'd0, 1'b0, 1'b1, 8'h0F);
    d_txn(64'h200, 64'd0, 1'b0, 8'h00, 64'h00000000_55667788, 1'b0, 1'b0, 8'h00);

    // Out-of-range store: no write, fault reported, low memory untouched
    d_txn(64'h100000, 64'hDEADBEEF_CAFEF00D, 1'b1, 8'hFF, 64'd0, 1'b1, 1'b0, 8'hFF);
    chk("oor_mem0_untouched", {56'd0, mem[0]}, 64'h00);

    // Zero-mask store: ACCESS happens, nothing changes
    d_txn(64'h200, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 8'h00, 64'd0, 1'b0, 1'b1, 8'h00);
    chk("mask0_byte_200", {56'd0, mem[20'h200]}, 64'h88);

    // Both ports valid every cycle: D D D D I D D D D I
    i_req_valid = 1'b1; i_req_addr = 64'h100; i_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_addr = 64'h200; d_req_wren = 1'b0; d_req_mask = 8'h00;
    d_req_data = 64'd0; d_rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k % 5 == 4);
      #1;
      chk("arb_i_ready", i_req_ready, exp_i);
      chk("arb_d_ready", d_req_ready, !exp_i);
      cyc;
      chk("arb_access_no_ready", {i_req_ready, d_req_ready}, 0);
      cyc;
      chk("arb_i_rsp_valid", i_rsp_valid, exp_i);
      chk("arb_d_rsp_valid", d_rsp_valid, !exp_i);
      if (exp_i) chk("arb_i_rsp_data", i_rsp_data, 32'h13);
      else       chk("arb_d_rsp_data", d_rsp_data, 64'h55667788);
      cyc;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;

    // Reset while a store is in its ACCESS cycle: the write must not land
    d_req_valid = 1'b1; d_req_addr = 64'h300; d_req_data = 64'hFFFFFFFF_FFFFFFFF;
    d_req_wren = 1'b1; d_req_mask = 8'hFF;
    #1;
    chk("rstacc_d_ready", d_req_ready, 1);
    cyc;
    d_req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rstacc_mem_wren", mem_wren, 0);
    cyc;
    rst = 1'b0;
    #1;
    chk("rstacc_d_rsp_valid", d_rsp_valid, 0);
    chk("rstacc_byte_300", {56'd0, mem[20'h300]}, 64'h00);
    d_txn(64'h300, 64'd0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 8'h00);

    // Response held off by d_rsp_ready = 0, then reset during the hold
    d_req_valid = 1'b1; d_req_addr = 64'h200; d_req_wren = 1'b0; d_req_mask = 8'h00;
    d_rsp_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 64'h100;
    #1;
    chk("hold_d_ready", d_req_ready, 1);
    cyc;
    cyc;
    for (int h = 0; h < 2; h++) begin
      chk("hold_d_rsp_valid", d_rsp_valid, 1);
      chk("hold_d_rsp_data", d_rsp_data, 64'h55667788);
      chk("hold_no_ready", {i_req_ready, d_req_ready}, 0);
      cyc;
    end
    rst = 1'b1; i_req_valid = 1'b0; d_req_valid = 1'b0;
    #1;
    chk("hold3_d_rsp_valid", d_rsp_valid, 1);
    cyc;
    rst = 1'b0;
    #1;
    chk("post_rst_d_rsp_valid", d_rsp_valid, 0);
    chk("post_rst_d_rsp_data", d_rsp_data, 0);
    chk("post_rst_i_rsp_valid", i_rsp_valid, 0);
    chk("post_rst_mem_addr", mem_addr, 0);
    d_req_valid = 1'b1;
    #1;
    chk("post_rst_idle_ready", d_req_ready, 1);
    d_req_valid = 1'b0;
    d_rsp_ready = 1'b1;
    cyc;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    i_txn(64'h102, 32'd0, 1'b1);
    d_txn(64'h204, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 8'hFF, 64'd0, 1'b1, 1'b0, 8'h00);
    chk("mis_byte_204", {56'd0, mem[20'h204]}, 64'h00);
`else
    i_txn(64'h102, 32'hCCDD0000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
